// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Datapath widths live here so the top and the result FIFO agree on them.
package rf_write_arbiter_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_AD_DEFAULT  = 4;
    localparam int MD_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_WB   = 2'd1,
        PORT_FIFO = 2'd2,
        PORT_MD   = 2'd3
    } port_src_e;

    // A one-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/md_result_fifo.sv
// Small circular FIFO holding mult/div results that lost the write port.
// Simultaneous push and pop keep the count unchanged and preserve order.
module md_result_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign head_data = mem_r[rd_ptr_r];

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and mult/div results,
// and keeps the busy scoreboard that stalls ID on pending mult/div destinations.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int REG_AD = REG_AD_DEFAULT,
    parameter int DEPTH  = MD_DEPTH_DEFAULT,
    parameter int DW     = DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [REG_AD:0] wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            md_valid,
    input  logic [REG_AD:0] md_addr,
    input  logic [DW-1:0]   md_data,
    output logic            md_ready,
    input  logic            issue_valid,
    input  logic [REG_AD:0] issue_addr,
    input  logic [REG_AD:0] chk_addr_1,
    input  logic [REG_AD:0] chk_addr_2,
    input  logic [REG_AD:0] chk_addr_d,
    output logic            stall,
    output logic            reg_we,
    output logic [REG_AD:0] reg_addr_3,
    output logic [DW-1:0]   reg_write_W
);

    localparam int AW   = REG_AD + 1;
    localparam int NREG = 1 << AW;
    localparam int EW   = AW + DW;

    port_src_e         port_src_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_data_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [EW-1:0]     fifo_head_s;
    logic              md_commit_s;
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;

    md_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_md_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data ({md_addr, md_data}),
        .pop       (fifo_pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Port source priority: writeback, then queued result, then bypass.
    always_comb begin
        port_src_s = PORT_IDLE;
        if (rst) begin
            port_src_s = PORT_IDLE;
        end else if (wb_we) begin
            port_src_s = PORT_WB;
        end else if (!fifo_empty_s) begin
            port_src_s = PORT_FIFO;
        end else if (md_valid) begin
            port_src_s = PORT_MD;
        end else begin
            port_src_s = PORT_IDLE;
        end
    end

    // Write-port data mux for the selected source.
    always_comb begin
        sel_addr_s = {AW{1'b0}};
        sel_data_s = {DW{1'b0}};
        case (port_src_s)
            PORT_WB: begin
                sel_addr_s = wb_addr;
                sel_data_s = wb_data;
            end
            PORT_FIFO: begin
                sel_addr_s = fifo_head_s[EW-1:DW];
                sel_data_s = fifo_head_s[DW-1:0];
            end
            PORT_MD: begin
                sel_addr_s = md_addr;
                sel_data_s = md_data;
            end
            default: begin
                sel_addr_s = {AW{1'b0}};
                sel_data_s = {DW{1'b0}};
            end
        endcase
    end

    // An address-0 md result still retires; only the write enable is masked.
    assign md_commit_s = (port_src_s == PORT_FIFO) || (port_src_s == PORT_MD);
    assign fifo_pop_s  = (port_src_s == PORT_FIFO);
    assign md_ready    = !rst && !fifo_full_s;
    assign fifo_push_s = md_valid && md_ready && (port_src_s != PORT_MD);

    assign reg_we      = (port_src_s != PORT_IDLE) && (sel_addr_s != {AW{1'b0}});
    assign reg_addr_3  = sel_addr_s;
    assign reg_write_W = sel_data_s;

    // Scoreboard update: a same-cycle issue wins over a commit to that register.
    always_comb begin
        busy_nxt_s = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            busy_nxt_s[i] = (issue_valid && (issue_addr == AW'(i))) ||
                            (busy_r[i] && !(md_commit_s && (sel_addr_s == AW'(i))));
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign stall = !rst && (busy_r[chk_addr_1] || busy_r[chk_addr_2] || busy_r[chk_addr_d]);

endmodule
